// File: rtl/mips_fetch_unit.sv
// MIPS instruction fetch stage: owns the PC, issues reads to instruction memory and feeds decode via a 2-entry buffer.
// Optional misaligned-redirect fault detection is enabled by defining FETCH_ALIGN_CHECK_EN.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned SEL_WORD_ADDR = 0
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] mem_sel,
  input  logic [31:0] mem_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        inflight_q, inflight_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] data_q [2];
  logic [31:0] data_d [2];
  logic [31:0] pc_q   [2];
  logic [31:0] pc_d   [2];
  logic        fault_q, fault_d;

  logic        deq;
  logic        push;
  logic        issue_ok;
  logic        misalign;
  logic [2:0]  credit;
  logic [2:0]  credit_after;
  logic [1:0]  after_pop;
  logic [31:0] target_pc;

  // Address is a pure function of the PC register so memory sees a stable request all cycle.
  generate
    if (SEL_WORD_ADDR != 0) begin : g_word_sel
      assign mem_sel = {2'b00, fetch_pc_q[31:2]};
    end else begin : g_byte_sel
      assign mem_sel = fetch_pc_q;
    end
  endgenerate

  assign inst_valid = (count_q != 2'd0);
  assign inst_data  = data_q[0];
  assign inst_pc    = pc_q[0];

`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign    = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign target_pc   = redirect_pc;
  assign fetch_fault = fault_q;
`else
  assign misalign    = 1'b0;
  assign target_pc   = redirect_pc & 32'hFFFF_FFFC;
  assign fetch_fault = 1'b0;
`endif

  always_comb begin
    deq       = inst_valid && inst_ready;
    push      = inflight_q && !redirect_valid;
    // Credit counts buffered plus in-flight words after this cycle's dequeue.
    credit    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, deq};
    issue_ok  = !redirect_valid && (state_q != S_FAULT) && (credit < 3'd2);
    after_pop = count_q - {1'b0, deq};

    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue_ok;
    fault_d    = fault_q || misalign;
    count_d    = count_q;
    data_d[0]  = data_q[0];
    data_d[1]  = data_q[1];
    pc_d[0]    = pc_q[0];
    pc_d[1]    = pc_q[1];

    if (redirect_valid) begin
      fetch_pc_d = target_pc;
    end else if (issue_ok) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      req_pc_d   = fetch_pc_q;
    end

    if (redirect_valid) begin
      count_d = 2'd0;
    end else begin
      if (deq) begin
        data_d[0] = data_q[1];
        pc_d[0]   = pc_q[1];
      end
      if (push) begin
        if (after_pop == 2'd0) begin
          data_d[0] = mem_out;
          pc_d[0]   = req_pc_q;
        end else begin
          data_d[1] = mem_out;
          pc_d[1]   = req_pc_q;
        end
      end
      count_d = after_pop + {1'b0, push};
    end

    credit_after = {1'b0, count_d} + {2'b00, inflight_d};
    state_d      = state_q;
    if (fault_d) begin
      state_d = S_FAULT;
    end else if (state_q != S_FAULT) begin
      state_d = (credit_after >= 3'd2) ? S_STALL : S_RUN;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_RUN;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'd0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      data_q[0]  <= 32'd0;
      data_q[1]  <= 32'd0;
      pc_q[0]    <= 32'd0;
      pc_q[1]    <= 32'd0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      data_q[0]  <= data_d[0];
      data_q[1]  <= data_d[1];
      pc_q[0]    <= pc_d[0];
      pc_q[1]    <= pc_d[1];
      fault_q    <= fault_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (count_q <= 2'd2);
    end
  end
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Scoreboard bench for mips_fetch_unit: a default instance and a word-addressed instance starting near the top of memory.
module tb_mips_fetch_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst0, rv0, ir0, iv0, ff0;
  logic [31:0] sel0, out0, rpc0, id0, ip0;
  logic        rst1, iv1, ff1;
  logic [31:0] sel1, out1, id1, ip1;

  int n_compared   = 0;
  int n_mismatched = 0;
  int xfer_cnt     = 0;
  int base_cnt     = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp1_q[$];

  mips_fetch_unit dut0 (
    .clock(clock), .reset(rst0), .mem_sel(sel0), .mem_out(out0),
    .redirect_valid(rv0), .redirect_pc(rpc0),
    .inst_valid(iv0), .inst_ready(ir0), .inst_data(id0), .inst_pc(ip0),
    .fetch_fault(ff0)
  );

  mips_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .SEL_WORD_ADDR(1)) dut1 (
    .clock(clock), .reset(rst1), .mem_sel(sel1), .mem_out(out1),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .inst_valid(iv1), .inst_ready(1'b1), .inst_data(id1), .inst_pc(ip1),
    .fetch_fault(ff1)
  );

  // Memory: word n holds 0x1000_0000 + n, returned the cycle after the address is sampled.
  always @(posedge clock) begin
    out0 <= 32'h1000_0000 + (sel0 >> 2);
    out1 <= 32'h1000_0000 + sel1;
  end

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'h1000_0000 + (pc >> 2);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic [31:0] e;
    @(negedge clock);
    if (!rst0 && iv0 && ir0) begin
      check_val("sb0_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_val("xfer0_pc", ip0, e);
        check_val("xfer0_data", id0, word_at(e));
      end
      xfer_cnt++;
      $display("xfer dut0 pc=%08h data=%08h", ip0, id0);
    end
    if (!rst1 && iv1) begin
      check_val("sb1_nonempty", 32'(exp1_q.size() != 0), 32'd1);
      if (exp1_q.size() != 0) begin
        e = exp1_q.pop_front();
        check_val("xfer1_pc", ip1, e);
        check_val("xfer1_data", id1, word_at(e));
      end
      $display("xfer dut1 pc=%08h data=%08h", ip1, id1);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst0 = 1'b1;
    rv0  = 1'b0;
    ir0  = 1'b0;
    tick();
    tick();
    exp_q.delete();
    rst0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; ir0 = 1'b0;
    rv0  = 1'b1; rpc0 = 32'h0000_0100;   // redirect during reset must be ignored
    tick(); tick(); tick();
    check_val("rst_valid", 32'(iv0), 32'd0);
    check_val("rst_pc", ip0, 32'd0);
    check_val("rst_data", id0, 32'd0);
    check_val("rst_sel", sel0, 32'd0);
    check_val("rst_fault", 32'(ff0), 32'd0);
    check_val("rst_sel1", sel1, 32'h3FFF_FFFE);
    check_val("rst_valid1", 32'(iv1), 32'd0);
    rv0 = 1'b0;

    // Streaming with ready held high
    rst0 = 1'b0; ir0 = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
    tick();
    check_val("lat_e1_valid", 32'(iv0), 32'd0);
    tick();
    check_val("lat_e2_valid", 32'(iv0), 32'd1);
    check_val("lat_e2_pc", ip0, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_val("thru_valid", 32'(iv0), 32'd1);
    end
    ir0 = 1'b0;
    check_val("p1_drain", 32'(exp_q.size()), 32'd0);

    // Back-pressure: outputs stable, fetch stops at 0x8
    do_reset();
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(4 * i));
    tick(); tick();
    check_val("p2_valid", 32'(iv0), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("stall_valid", 32'(iv0), 32'd1);
      check_val("stall_pc", ip0, 32'd0);
      check_val("stall_data", id0, 32'h1000_0000);
    end
    check_val("stall_sel", sel0, 32'h8);
    ir0 = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    ir0 = 1'b0;
    check_val("p2_drain", 32'(exp_q.size()), 32'd0);

    // Redirect with a buffered word and one in flight
    do_reset();
    tick(); tick();
    check_val("p3_pre_valid", 32'(iv0), 32'd1);
    rv0 = 1'b1; rpc0 = 32'h40;
    tick();
    rv0 = 1'b0;
    check_val("p3_flush_valid", 32'(iv0), 32'd0);
    check_val("p3_sel", sel0, 32'h40);
    exp_q.push_back(32'h40); exp_q.push_back(32'h44); exp_q.push_back(32'h48);
    ir0 = 1'b1;
    tick();
    check_val("p3_lat1_valid", 32'(iv0), 32'd0);
    tick();
    check_val("p3_lat2_valid", 32'(iv0), 32'd1);
    check_val("p3_lat2_pc", ip0, 32'h40);
    tick(); tick(); tick();
    ir0 = 1'b0;
    check_val("p3_drain", 32'(exp_q.size()), 32'd0);

    // Redirect coincident with a transfer from a full buffer
    do_reset();
    tick(); tick(); tick();
    check_val("p4_full_sel", sel0, 32'h8);
    exp_q.push_back(32'h0);
    base_cnt = xfer_cnt;
    ir0 = 1'b1; rv0 = 1'b1; rpc0 = 32'h80;
    tick();
    rv0 = 1'b0; ir0 = 1'b0;
    check_val("p4_once", 32'(xfer_cnt - base_cnt), 32'd1);
    check_val("p4_flush_valid", 32'(iv0), 32'd0);
    check_val("p4_sb_empty", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(32'h80);
    ir0 = 1'b1;
    tick();
    check_val("p4_lat1_valid", 32'(iv0), 32'd0);
    tick();
    check_val("p4_lat2_valid", 32'(iv0), 32'd1);
    check_val("p4_lat2_pc", ip0, 32'h80);
    tick();
    ir0 = 1'b0;
    check_val("p4_drain", 32'(exp_q.size()), 32'd0);
    check_val("p4_total", 32'(xfer_cnt - base_cnt), 32'd2);

    // Back-to-back redirects: last one wins
    do_reset();
    tick(); tick();
    rv0 = 1'b1; rpc0 = 32'h100;
    tick();
    rpc0 = 32'h200;
    tick();
    rv0 = 1'b0;
    check_val("b2b_sel", sel0, 32'h200);
    tick();
    check_val("b2b_lat1_valid", 32'(iv0), 32'd0);
    tick();
    check_val("b2b_valid", 32'(iv0), 32'd1);
    check_val("b2b_pc", ip0, 32'h200);
    check_val("b2b_data", id0, word_at(32'h200));

    // PC wrap on the word-addressed instance
    exp1_q.push_back(32'hFFFF_FFF8); exp1_q.push_back(32'hFFFF_FFFC); exp1_q.push_back(32'h0);
    rst1 = 1'b0;
    check_val("wrap_sel0", sel1, 32'h3FFF_FFFE);
    tick();
    check_val("wrap_sel1", sel1, 32'h3FFF_FFFF);
    check_val("wrap_valid_e1", 32'(iv1), 32'd0);
    tick();
    check_val("wrap_sel2", sel1, 32'h0);
    check_val("wrap_valid_e2", 32'(iv1), 32'd1);
    check_val("wrap_pc0", ip1, 32'hFFFF_FFF8);
    tick();
    check_val("wrap_pc1", ip1, 32'hFFFF_FFFC);
    tick();
    check_val("wrap_pc2", ip1, 32'h0);
    tick();
    rst1 = 1'b1;
    tick();
    check_val("wrap_drain", 32'(exp1_q.size()), 32'd0);
    check_val("wrap_fault", 32'(ff1), 32'd0);

    // Misaligned redirect
    do_reset();
    tick(); tick();
    rv0 = 1'b1; rpc0 = 32'h42;
    tick();
    rv0 = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    check_val("align_fault_set", 32'(ff0), 32'd1);
    check_val("align_sel", sel0, 32'h42);
    ir0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("align_no_valid", 32'(iv0), 32'd0);
      check_val("align_sticky", 32'(ff0), 32'd1);
    end
    ir0 = 1'b0;
    rst0 = 1'b1;
    tick();
    check_val("align_fault_clr", 32'(ff0), 32'd0);
    rst0 = 1'b0;
    tick(); tick();
    check_val("align_recover_valid", 32'(iv0), 32'd1);
    check_val("align_recover_pc", ip0, 32'h0);
`else
    check_val("align_fault_off", 32'(ff0), 32'd0);
    check_val("align_sel", sel0, 32'h40);
    exp_q.push_back(32'h40); exp_q.push_back(32'h44);
    ir0 = 1'b1;
    tick();
    check_val("align_lat1_valid", 32'(iv0), 32'd0);
    tick();
    check_val("align_valid", 32'(iv0), 32'd1);
    check_val("align_pc", ip0, 32'h40);
    tick(); tick();
    ir0 = 1'b0;
    check_val("align_drain", 32'(exp_q.size()), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
